// File: rtl/t5_hsch.sv
// rtl/t5_hsch.sv - round-robin hart scheduler with per-hart PC file for the t5 barrel core
module t5_hsch #(
    parameter int              XLEN  = 32,
    parameter int              NHART = 4,
    parameter int              HW    = 2,
    parameter int              LAT   = 2,
    parameter logic [XLEN-1:0] RSTPC = '0
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              sena,
    input  logic              stall,
    input  logic [NHART-1:0]  hena,
    input  logic [NHART-1:0]  hirq,
    input  logic              xbra,
    input  logic [XLEN-1:0]   xbpc,
    input  logic              xwfi,
    output logic              fvld,
    output logic [HW-1:0]     fhart,
    output logic [XLEN-1:0]   fpc,
    output logic              xvld,
    output logic [HW-1:0]     xhart,
    output logic [NHART-1:0]  hact
);

    logic [XLEN-1:0]  pc_q [NHART];
    logic [XLEN-1:0]  pc_d [NHART];
    logic [NHART-1:0] park_q, park_d;
    logic [NHART-1:0] infl_q, infl_d;
    logic [HW-1:0]    rr_q, rr_d;
    logic             fvld_q, fvld_d;
    logic [HW-1:0]    fhart_q, fhart_d;
    logic [XLEN-1:0]  fpc_q, fpc_d;
    // pipe stages 1..LAT live at indices 0..LAT-1; the last one is the retire slot
    logic [LAT-1:0]   pv_q, pv_d;
    logic [HW-1:0]    ph_q [LAT];
    logic [HW-1:0]    ph_d [LAT];

    logic             adv;
    logic [NHART-1:0] retiring;
    logic [NHART-1:0] elig;
    logic             found;
    logic [HW-1:0]    sel;
    logic [XLEN-1:0]  bra_pc;
    logic [XLEN-1:0]  issue_pc;

    assign adv    = sena & ~stall;
    assign bra_pc = xbpc & ~(XLEN'(3));

    // retire decode, eligibility, round-robin pick and all next-state values
    always_comb begin
        found    = 1'b0;
        sel      = '0;
        issue_pc = '0;
        park_d   = park_q;
        infl_d   = infl_q;
        rr_d     = rr_q;
        fvld_d   = fvld_q;
        fhart_d  = fhart_q;
        fpc_d    = fpc_q;
        pv_d     = pv_q;
        for (int k = 0; k < LAT; k++) ph_d[k] = ph_q[k];
        for (int h = 0; h < NHART; h++) pc_d[h] = pc_q[h];

        for (int h = 0; h < NHART; h++) begin
            retiring[h] = adv & pv_q[LAT-1] & (ph_q[LAT-1] == HW'(h));
            // a hart retiring this edge may be picked again straight away
            elig[h]     = hena[h] & ~park_q[h] & (~infl_q[h] | retiring[h]);
        end

        // scan starts just past the last issued hart and wraps at NHART-1
        for (int i = 1; i <= NHART; i++) begin
            int idx;
            idx = (int'(rr_q) + i) % NHART;
            if (!found && elig[idx]) begin
                found = 1'b1;
                sel   = HW'(idx);
            end
        end
        issue_pc = (retiring[sel] & xbra) ? bra_pc : pc_q[sel];

        if (adv) begin
            for (int h = 0; h < NHART; h++) begin
                if (retiring[h]) begin
                    infl_d[h] = 1'b0;
                    if (xbra) pc_d[h] = bra_pc;
                end
            end
            fvld_d = found;
            if (found) begin
                fhart_d     = sel;
                fpc_d       = issue_pc;
                rr_d        = sel;
                infl_d[sel] = 1'b1;
                // issue increment overrides a redirect landing on the same hart
                pc_d[sel]   = issue_pc + XLEN'(4);
            end
            pv_d[0] = fvld_q;
            ph_d[0] = fhart_q;
            for (int k = 1; k < LAT; k++) begin
                pv_d[k] = pv_q[k-1];
                ph_d[k] = ph_q[k-1];
            end
        end

        // wake runs every edge and beats a WFI retiring in the same edge
        for (int h = 0; h < NHART; h++) begin
            if (retiring[h] && xwfi) park_d[h] = 1'b1;
            if (hirq[h])             park_d[h] = 1'b0;
        end
    end

    // state registers; asynchronous reset drops everything in flight
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            for (int h = 0; h < NHART; h++) pc_q[h] <= RSTPC;
            park_q  <= '0;
            infl_q  <= '0;
            rr_q    <= HW'(NHART - 1);
            fvld_q  <= 1'b0;
            fhart_q <= '0;
            fpc_q   <= RSTPC;
            pv_q    <= '0;
            for (int k = 0; k < LAT; k++) ph_q[k] <= '0;
        end else begin
            for (int h = 0; h < NHART; h++) pc_q[h] <= pc_d[h];
            park_q  <= park_d;
            infl_q  <= infl_d;
            rr_q    <= rr_d;
            fvld_q  <= fvld_d;
            fhart_q <= fhart_d;
            fpc_q   <= fpc_d;
            pv_q    <= pv_d;
            for (int k = 0; k < LAT; k++) ph_q[k] <= ph_d[k];
        end
    end

    assign fvld  = fvld_q;
    assign fhart = fhart_q;
    assign fpc   = fpc_q;
    assign xvld  = pv_q[LAT-1];
    assign xhart = ph_q[LAT-1];
    assign hact  = hena & ~park_q;

endmodule

// File: tb/tb_t5_hsch.sv
// tb/tb_t5_hsch.sv - table-driven scoreboard bench for t5_hsch
module tb_t5_hsch;

    localparam int          XLEN  = 32;
    localparam int          NHART = 4;
    localparam int          HW    = 2;
    localparam int          LAT   = 2;
    localparam logic [31:0] RSTPC = 32'h100;

    logic              sys_clk = 1'b0;
    logic              sys_rst = 1'b0;
    logic              sena    = 1'b1;
    logic              stall   = 1'b0;
    logic [NHART-1:0]  hena    = 4'hF;
    logic [NHART-1:0]  hirq    = 4'h0;
    logic              xbra    = 1'b0;
    logic [XLEN-1:0]   xbpc    = '0;
    logic              xwfi    = 1'b0;
    logic              fvld;
    logic [HW-1:0]     fhart;
    logic [XLEN-1:0]   fpc;
    logic              xvld;
    logic [HW-1:0]     xhart;
    logic [NHART-1:0]  hact;

    t5_hsch #(.XLEN(XLEN), .NHART(NHART), .HW(HW), .LAT(LAT), .RSTPC(RSTPC)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .sena(sena), .stall(stall),
        .hena(hena), .hirq(hirq), .xbra(xbra), .xbpc(xbpc), .xwfi(xwfi),
        .fvld(fvld), .fhart(fhart), .fpc(fpc), .xvld(xvld), .xhart(xhart),
        .hact(hact)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic        sena;
        logic        stall;
        logic [3:0]  hena;
        logic [3:0]  hirq;
        logic        xbra;
        logic [31:0] xbpc;
        logic        xwfi;
        logic        fvld;
        logic [1:0]  fhart;
        logic [31:0] fpc;
        logic        xvld;
        logic [1:0]  xhart;
        logic [3:0]  hact;
    } vec_t;

    typedef struct {
        logic        fvld;
        logic [1:0]  fhart;
        logic [31:0] fpc;
        logic        xvld;
        logic [1:0]  xhart;
        logic [3:0]  hact;
    } exp_t;

    vec_t tbl[$];
    exp_t sbq[$];
    int   n_err = 0;
    int   n_chk = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic add(input logic sn, input logic st, input logic [3:0] he, input logic [3:0] hi,
                       input logic xb, input logic [31:0] xp, input logic xw,
                       input logic ev, input logic [1:0] eh, input logic [31:0] ep,
                       input logic exv, input logic [1:0] exh, input logic [3:0] eact);
        vec_t v;
        v.sena = sn;  v.stall = st; v.hena = he; v.hirq = hi;
        v.xbra = xb;  v.xbpc = xp;  v.xwfi = xw;
        v.fvld = ev;  v.fhart = eh; v.fpc = ep;
        v.xvld = exv; v.xhart = exh; v.hact = eact;
        tbl.push_back(v);
    endtask

    // first n cycles of a four-hart rotation from reset with no stalls
    task automatic base(input int n);
        for (int i = 0; i < n; i++)
            add(1, 0, 4'hF, 4'h0, 0, 0, 0, 1, 2'(i % 4), (i < 4) ? 32'h100 : 32'h104,
                i >= 2, 2'((i + 2) % 4), 4'hF);
    endtask

    task automatic run_tbl(input string nm);
        exp_t e;
        for (int i = 0; i < tbl.size(); i++) begin
            sena  = tbl[i].sena;  stall = tbl[i].stall; hena = tbl[i].hena;
            hirq  = tbl[i].hirq;  xbra  = tbl[i].xbra;  xbpc = tbl[i].xbpc;
            xwfi  = tbl[i].xwfi;
            e.fvld = tbl[i].fvld; e.fhart = tbl[i].fhart; e.fpc = tbl[i].fpc;
            e.xvld = tbl[i].xvld; e.xhart = tbl[i].xhart; e.hact = tbl[i].hact;
            sbq.push_back(e);
            @(posedge sys_clk);
            #1;
            e = sbq.pop_front();
            chk($sformatf("%s[%0d].fvld", nm, i + 1), 32'(fvld), 32'(e.fvld));
            chk($sformatf("%s[%0d].fhart", nm, i + 1), 32'(fhart), 32'(e.fhart));
            chk($sformatf("%s[%0d].fpc", nm, i + 1), fpc, e.fpc);
            chk($sformatf("%s[%0d].xvld", nm, i + 1), 32'(xvld), 32'(e.xvld));
            if (e.xvld) chk($sformatf("%s[%0d].xhart", nm, i + 1), 32'(xhart), 32'(e.xhart));
            chk($sformatf("%s[%0d].hact", nm, i + 1), 32'(hact), 32'(e.hact));
        end
        tbl.delete();
    endtask

    // reset asserted between edges, outputs checked before the next edge
    task automatic do_reset(input string nm, input logic [3:0] he);
        sena = 1; stall = 0; hirq = 0; xbra = 0; xbpc = 0; xwfi = 0; hena = he;
        @(posedge sys_clk);
        #3;
        sys_rst = 1'b0;
        #1;
        chk({nm, ".rst.fvld"}, 32'(fvld), 32'd0);
        chk({nm, ".rst.fhart"}, 32'(fhart), 32'd0);
        chk({nm, ".rst.fpc"}, fpc, RSTPC);
        chk({nm, ".rst.xvld"}, 32'(xvld), 32'd0);
        chk({nm, ".rst.xhart"}, 32'(xhart), 32'd0);
        chk({nm, ".rst.hact"}, 32'(hact), 32'(he));
        @(posedge sys_clk);
        #3;
        sys_rst = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: run did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        // full round-robin
        do_reset("t1", 4'hF);
        base(8);
        run_tbl("t1");

        // single hart issues once every LAT+1 cycles
        do_reset("t2", 4'h1);
        add(1, 0, 4'h1, 0, 0, 0, 0, 1, 0, 32'h100, 0, 0, 4'h1);
        add(1, 0, 4'h1, 0, 0, 0, 0, 0, 0, 32'h100, 0, 0, 4'h1);
        add(1, 0, 4'h1, 0, 0, 0, 0, 0, 0, 32'h100, 1, 0, 4'h1);
        add(1, 0, 4'h1, 0, 0, 0, 0, 1, 0, 32'h104, 0, 0, 4'h1);
        add(1, 0, 4'h1, 0, 0, 0, 0, 0, 0, 32'h104, 0, 0, 4'h1);
        add(1, 0, 4'h1, 0, 0, 0, 0, 0, 0, 32'h104, 1, 0, 4'h1);
        add(1, 0, 4'h1, 0, 0, 0, 0, 1, 0, 32'h108, 0, 0, 4'h1);
        run_tbl("t2");

        // redirect of hart 2 at retire
        do_reset("t3a", 4'hF);
        base(5);
        add(1, 0, 4'hF, 0, 1, 32'h1003, 0, 1, 1, 32'h104, 1, 3, 4'hF);
        add(1, 0, 4'hF, 0, 0, 0, 0, 1, 2, 32'h1000, 1, 0, 4'hF);
        add(1, 0, 4'hF, 0, 0, 0, 0, 1, 3, 32'h104, 1, 1, 4'hF);
        add(1, 0, 4'hF, 0, 0, 0, 0, 1, 0, 32'h108, 1, 2, 4'hF);
        add(1, 0, 4'hF, 0, 0, 0, 0, 1, 1, 32'h108, 1, 3, 4'hF);
        add(1, 0, 4'hF, 0, 0, 0, 0, 1, 2, 32'h1004, 1, 0, 4'hF);
        run_tbl("t3a");

        // redirect through the retire bypass
        do_reset("t3b", 4'h4);
        add(1, 0, 4'h4, 0, 0, 0, 0, 1, 2, 32'h100, 0, 0, 4'h4);
        add(1, 0, 4'h4, 0, 0, 0, 0, 0, 2, 32'h100, 0, 0, 4'h4);
        add(1, 0, 4'h4, 0, 0, 0, 0, 0, 2, 32'h100, 1, 2, 4'h4);
        add(1, 0, 4'h4, 0, 1, 32'h1003, 0, 1, 2, 32'h1000, 0, 0, 4'h4);
        add(1, 0, 4'h4, 0, 0, 0, 0, 0, 2, 32'h1000, 0, 0, 4'h4);
        add(1, 0, 4'h4, 0, 0, 0, 0, 0, 2, 32'h1000, 1, 2, 4'h4);
        add(1, 0, 4'h4, 0, 0, 0, 0, 1, 2, 32'h1004, 0, 0, 4'h4);
        run_tbl("t3b");

        // stall and enable-low hold while hart 1 retires with a redirect
        do_reset("t4", 4'hF);
        base(4);
        for (int i = 0; i < 3; i++)
            add(1, 1, 4'hF, 0, 1, 32'h1000, 0, 1, 3, 32'h100, 1, 1, 4'hF);
        add(0, 0, 4'hF, 0, 1, 32'h1000, 0, 1, 3, 32'h100, 1, 1, 4'hF);
        add(1, 0, 4'hF, 0, 1, 32'h1000, 0, 1, 0, 32'h104, 1, 2, 4'hF);
        add(1, 0, 4'hF, 0, 0, 0, 0, 1, 1, 32'h1000, 1, 3, 4'hF);
        add(1, 0, 4'hF, 0, 0, 0, 0, 1, 2, 32'h104, 1, 0, 4'hF);
        add(1, 0, 4'hF, 0, 0, 0, 0, 1, 3, 32'h104, 1, 1, 4'hF);
        add(1, 0, 4'hF, 0, 0, 0, 0, 1, 0, 32'h108, 1, 2, 4'hF);
        add(1, 0, 4'hF, 0, 0, 0, 0, 1, 1, 32'h1004, 1, 3, 4'hF);
        run_tbl("t4");

        // WFI parks hart 1, interrupt wakes it at its pre-park PC+4
        do_reset("t5", 4'hF);
        base(4);
        add(1, 0, 4'hF, 0, 0, 0, 1, 1, 0, 32'h104, 1, 2, 4'hD);
        add(1, 0, 4'hF, 0, 0, 0, 0, 1, 2, 32'h104, 1, 3, 4'hD);
        add(1, 0, 4'hF, 0, 0, 0, 0, 1, 3, 32'h104, 1, 0, 4'hD);
        add(1, 0, 4'hF, 0, 0, 0, 0, 1, 0, 32'h108, 1, 2, 4'hD);
        add(1, 0, 4'hF, 0, 0, 0, 0, 1, 2, 32'h108, 1, 3, 4'hD);
        add(1, 0, 4'hF, 0, 0, 0, 0, 1, 3, 32'h108, 1, 0, 4'hD);
        add(1, 0, 4'hF, 4'h2, 0, 0, 0, 1, 0, 32'h10C, 1, 2, 4'hF);
        add(1, 0, 4'hF, 0, 0, 0, 0, 1, 1, 32'h104, 1, 3, 4'hF);
        run_tbl("t5");

        // WFI and interrupt in the same edge: hart stays awake
        do_reset("t5b", 4'hF);
        base(4);
        add(1, 0, 4'hF, 4'h2, 0, 0, 1, 1, 0, 32'h104, 1, 2, 4'hF);
        add(1, 0, 4'hF, 0, 0, 0, 0, 1, 1, 32'h104, 1, 3, 4'hF);
        run_tbl("t5b");

        // reset in the middle of a running rotation
        do_reset("t6", 4'hF);
        base(3);
        run_tbl("t6a");
        do_reset("t6", 4'hF);
        base(2);
        run_tbl("t6b");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
